frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter PRESC_BASE, default 16, base log2 of the step period in clk cycles.
REQ-002 Parameter NUM_ANI, default 34, number of valid animation indices (0..NUM_ANI-1).
REQ-003 Parameter LOOPS, default 2, full animation passes before auto-advance.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ena  in  1  global enable; low freezes all state and suppresses pulses.
REQ-007 speed  in  3  step-period select; period = 2^(PRESC_BASE+speed) cycles.
REQ-008 auto_mode  in  1  1 = cycle animations automatically, 0 = follow ani_sel.
REQ-009 ani_sel  in  6  requested animation index (manual mode).
REQ-010 limit  in  6  last frame index of current animation, from the animation-limit lookup stage.
REQ-011 animation  out  6  current animation index, registered; drives the lookup stage.
REQ-012 frame  out  6  current frame index, registered.
REQ-013 frame_stb  out  1  one-cycle pulse whenever frame or animation is updated.
REQ-014 ani_done  out  1  one-cycle pulse when the last frame of a pass completes.

Function
REQ-015 Prescaler counter (width PRESC_BASE+7) increments each ena cycle; tick is asserted when counter >= 2^(PRESC_BASE+speed)-1, and the counter then returns to 0.
REQ-016 A speed change that lowers the terminal below the current count produces a tick on the next ena cycle, never a counter wrap.
REQ-017 On tick: if frame >= limit, frame := 0, ani_done pulses, and loop_cnt increments; otherwise frame := frame+1.
REQ-018 frame_stb pulses in the cycle after every tick and after every animation load; frame and animation are valid in that same cycle.
REQ-019 Manual mode: a sel-change event occurs when ani_sel differs from registered prev_sel; prev_sel := ani_sel every ena cycle.
REQ-020 On a sel-change event: animation := ani_sel, or 0 if ani_sel >= NUM_ANI; frame, prescaler, and loop_cnt := 0; frame_stb pulses; ani_done stays low.
REQ-021 A sel-change event takes priority over a tick in the same cycle; that tick is discarded.
REQ-022 Auto mode: ani_sel is ignored for loading, but prev_sel still tracks it.
REQ-023 Auto mode, when a wrap brings loop_cnt to LOOPS: animation := animation+1 (NUM_ANI-1 wraps to 0); loop_cnt := 0; frame := 0; ani_done pulses.
REQ-024 Switching auto_mode 1->0 produces no load until the next sel-change; 0->1 continues from the current animation with loop_cnt unchanged.
REQ-025 limit is sampled combinationally each tick; limit 0 yields frame fixed at 0 with ani_done on every tick; limit 63 (undefined-index default) is legal.
REQ-026 Frame arithmetic is 6-bit unsigned; frame never exceeds max(limit, previous frame) and never wraps via overflow.
REQ-027 ena low: no counter, register, or pulse changes; a pending tick condition is evaluated once ena returns high.

Reset
REQ-028 When rst=1 at a clock edge: animation, frame, prev_sel, loop_cnt, and prescaler := 0; frame_stb and ani_done := 0.
REQ-029 rst has priority over ena, tick, and sel-change; reset mid-animation discards all progress.
REQ-030 After reset, in manual mode with ani_sel != 0, the first ena cycle produces a sel-change load.

Structure
REQ-031 Shared package holds NUM_ANI default, ANI_W=6, FRAME_W=6, SPEED_W=3.
REQ-032 The prescaler is one sub-module, tick_gen (inputs clk, rst, ena, clr, speed; output tick).
REQ-033 All other logic is flat in frame_sequencer; no combinational path from limit to any output.

Verification (PRESC_BASE=2, NUM_ANI=34, LOOPS=2)
REQ-034 rst, speed=0, manual, ani_sel=0, limit=9, ena=1 -> frame_stb every 4 cycles; frame 0..9 then 0; ani_done with the 9->0 step.
REQ-035 ani_sel 0->1 mid-pass at frame=5 -> next cycle animation=1, frame=0, frame_stb=1, ani_done=0; prescaler restarts, next step 4 cycles later.
REQ-036 auto_mode=1, animation=33, limit=8 -> after 2 passes (18 ticks) animation=0, frame=0, ani_done=1.
REQ-037 speed 3->0 with prescaler at 20 -> tick on next cycle, then period 4.
REQ-038 ani_sel=40 -> animation=0; limit lowered from 9 to 3 at frame=7 -> next tick frame=0 with ani_done.
REQ-039 rst at frame=6 during ena=0 -> all outputs 0 next cycle; ena low 10 cycles -> outputs frozen, no pulses.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// frame_sequencer_pkg : shared widths and defaults for the frame sequencer
// Revision: 1.0
// ============================================================================
package frame_sequencer_pkg;

  localparam int NUM_ANI_DEFAULT = 34;
  localparam int ANI_W           = 6;
  localparam int FRAME_W         = 6;
  localparam int SPEED_W         = 3;

  typedef logic [ANI_W-1:0]   ani_t;
  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [SPEED_W-1:0] speed_t;

endpackage
`default_nettype wire

// File: rtl/frame_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
// tick_gen : step prescaler, one tick every 2^(PRESC_BASE+speed) enabled cycles
// Revision: 1.0
// ============================================================================
module tick_gen
  import frame_sequencer_pkg::*;
#(
  parameter int PRESC_BASE = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  logic   clr,
  input  speed_t speed,
  output logic   tick
);

  localparam int CW = PRESC_BASE + 7;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_term;
  logic          w_hit;

  // speed=7 shifts the one out entirely, so the terminal becomes all ones
  assign w_term = (CW'(1) << (PRESC_BASE + int'(speed))) - CW'(1);
  assign w_hit  = (r_cnt >= w_term);
  assign tick   = ena & w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ena) begin
      if (clr || w_hit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// frame_sequencer : steps frames of the current animation, manual or auto-cycling
// Revision: 1.0
// ============================================================================
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int PRESC_BASE = 16,
  parameter int NUM_ANI    = NUM_ANI_DEFAULT,
  parameter int LOOPS      = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  speed_t speed,
  input  logic   auto_mode,
  input  ani_t   ani_sel,
  input  frame_t limit,
  output ani_t   animation,
  output frame_t frame,
  output logic   frame_stb,
  output logic   ani_done
);

  localparam int LOOP_W = $clog2(LOOPS + 1);

  ani_t              r_animation;
  frame_t            r_frame;
  ani_t              r_prev_sel;
  logic [LOOP_W-1:0] r_loop_cnt;
  logic              r_frame_stb;
  logic              r_ani_done;
  logic              w_sel_change;
  logic              w_tick;

  assign w_sel_change = ~auto_mode & (ani_sel != r_prev_sel);

  tick_gen #(
    .PRESC_BASE (PRESC_BASE)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .clr   (w_sel_change),
    .speed (speed),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_animation <= '0;
      r_frame     <= '0;
      r_prev_sel  <= '0;
      r_loop_cnt  <= '0;
      r_frame_stb <= 1'b0;
      r_ani_done  <= 1'b0;
    end else if (!ena) begin
      r_frame_stb <= 1'b0;
      r_ani_done  <= 1'b0;
    end else begin
      r_prev_sel  <= ani_sel;
      r_frame_stb <= 1'b0;
      r_ani_done  <= 1'b0;
      if (w_sel_change) begin
        // a load discards any tick arriving in the same cycle
        r_animation <= (ani_sel >= ANI_W'(NUM_ANI)) ? '0 : ani_sel;
        r_frame     <= '0;
        r_loop_cnt  <= '0;
        r_frame_stb <= 1'b1;
      end else if (w_tick) begin
        r_frame_stb <= 1'b1;
        if (r_frame >= limit) begin
          r_frame    <= '0;
          r_ani_done <= 1'b1;
          if (auto_mode && (r_loop_cnt >= LOOP_W'(LOOPS - 1))) begin
            r_animation <= (r_animation == ANI_W'(NUM_ANI - 1)) ? '0 : r_animation + 1'b1;
            r_loop_cnt  <= '0;
          end else if (r_loop_cnt < LOOP_W'(LOOPS)) begin
            // saturates in manual mode so a later switch to auto advances on the next wrap
            r_loop_cnt <= r_loop_cnt + 1'b1;
          end
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  assign animation = r_animation;
  assign frame     = r_frame;
  assign frame_stb = r_frame_stb;
  assign ani_done  = r_ani_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tb_frame_sequencer : vector table, corner sequences and random run vs a reference model
// Revision: 1.0
// ============================================================================
module tb_frame_sequencer;

  localparam int PB      = 2;
  localparam int NUM_ANI = 34;
  localparam int LOOPS   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       auto_mode = 1'b0;
  logic [5:0] ani_sel = 6'd0;
  logic [5:0] limit = 6'd9;
  logic [5:0] animation;
  logic [5:0] frame;
  logic       frame_stb;
  logic       ani_done;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_ani, m_frame, m_loops, m_cnt, m_prev;
  int e_stb, e_done;

  frame_sequencer #(
    .PRESC_BASE (PB),
    .NUM_ANI    (NUM_ANI),
    .LOOPS      (LOOPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .speed     (speed),
    .auto_mode (auto_mode),
    .ani_sel   (ani_sel),
    .limit     (limit),
    .animation (animation),
    .frame     (frame),
    .frame_stb (frame_stb),
    .ani_done  (ani_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ena, auto_m;
    logic [2:0] speed;
    logic [5:0] sel, lim, ani, frm;
    logic       stb, done;
  } vec_t;

  function automatic vec_t mk(input int r, input int e, input int a, input int s,
                              input int sl, input int lm, input int an, input int fr,
                              input int sb, input int dn);
    vec_t v;
    v.rst = r[0]; v.ena = e[0]; v.auto_m = a[0]; v.speed = 3'(s);
    v.sel = 6'(sl); v.lim = 6'(lm); v.ani = 6'(an); v.frm = 6'(fr);
    v.stb = sb[0]; v.done = dn[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model of one clock edge using the current inputs
  task automatic model_clock();
    int period;
    bit tick, chg;
    if (rst) begin
      m_ani = 0; m_frame = 0; m_loops = 0; m_cnt = 0; m_prev = 0; e_stb = 0; e_done = 0;
    end else if (!ena) begin
      e_stb = 0; e_done = 0;
    end else begin
      period = 1 << (PB + int'(speed));
      tick   = (m_cnt >= period - 1);
      chg    = !auto_mode && (int'(ani_sel) != m_prev);
      m_prev = int'(ani_sel);
      e_stb  = 0; e_done = 0;
      if (chg) begin
        m_ani   = (int'(ani_sel) < NUM_ANI) ? int'(ani_sel) : 0;
        m_frame = 0; m_loops = 0; m_cnt = 0; e_stb = 1;
      end else begin
        m_cnt = tick ? 0 : m_cnt + 1;
        if (tick) begin
          e_stb = 1;
          if (m_frame >= int'(limit)) begin
            m_frame = 0; e_done = 1; m_loops++;
            if (auto_mode && m_loops >= LOOPS) begin
              m_ani   = (m_ani + 1) % NUM_ANI;
              m_loops = 0;
            end
          end else begin
            m_frame++;
          end
        end
      end
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".animation"}, animation, m_ani);
    chk({tag, ".frame"}, frame, m_frame);
    chk({tag, ".frame_stb"}, frame_stb, e_stb);
    chk({tag, ".ani_done"}, ani_done, e_done);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      cmp_model(tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    cmp_model("reset");
    rst = 1'b0;
  endtask

  vec_t tbl[17];

  initial begin
    int nstb, ndone, pre_done, pf;

    tbl[0]  = mk(1, 0, 0, 0,  0,  9,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0,  5,  9,  5, 0, 1, 0);
    tbl[2]  = mk(0, 1, 0, 0, 40,  9,  0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 40,  9,  0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 33,  9, 33, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0,  7,  9, 33, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0,  7,  9,  7, 0, 1, 0);
    tbl[7]  = mk(0, 1, 1, 0,  9,  9,  7, 0, 0, 0);
    tbl[8]  = mk(1, 1, 1, 0,  9,  9,  0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0,  0,  9,  0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0,  0,  9,  0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 0,  0,  9,  0, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0,  0,  0,  0, 0, 1, 1);
    tbl[13] = mk(0, 1, 0, 0,  0, 63,  0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0,  0, 63,  0, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0,  0, 63,  0, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 0,  0, 63,  0, 1, 1, 0);

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; ena = tbl[i].ena; auto_mode = tbl[i].auto_m;
      speed = tbl[i].speed; ani_sel = tbl[i].sel; limit = tbl[i].lim;
      step();
      chk($sformatf("vec%0d.animation", i), animation, tbl[i].ani);
      chk($sformatf("vec%0d.frame", i), frame, tbl[i].frm);
      chk($sformatf("vec%0d.frame_stb", i), frame_stb, tbl[i].stb);
      chk($sformatf("vec%0d.ani_done", i), ani_done, tbl[i].done);
    end

    // basic stepping, then a mid-pass selection change
    ena = 1'b1; speed = 3'd0; auto_mode = 1'b0; ani_sel = 6'd0; limit = 6'd9;
    do_reset();
    nstb = 0; ndone = 0; pre_done = -1;
    for (int i = 0; i < 44; i++) begin
      pf = frame;
      step();
      cmp_model("seq_basic");
      if (frame_stb) nstb++;
      if (ani_done) begin ndone++; pre_done = pf; end
    end
    chk("basic.stb_count", nstb, 11);
    chk("basic.done_count", ndone, 1);
    chk("basic.frame_before_done", pre_done, 9);
    chk("basic.frame_end", frame, 1);
    run(16, "seq_basic2");
    chk("midpass.frame", frame, 5);
    ani_sel = 6'd1;
    step();
    cmp_model("sel_change");
    chk("sel_change.animation", animation, 1);
    chk("sel_change.frame", frame, 0);
    chk("sel_change.stb", frame_stb, 1);
    chk("sel_change.done", ani_done, 0);
    nstb = 0;
    for (int i = 0; i < 3; i++) begin step(); cmp_model("after_sel"); nstb += frame_stb; end
    chk("after_sel.quiet_stb", nstb, 0);
    step(); cmp_model("after_sel");
    chk("after_sel.stb4", frame_stb, 1);
    chk("after_sel.frame", frame, 1);

    // auto mode wraps from the last animation to zero after two passes
    do_reset();
    ani_sel = 6'd33; limit = 6'd8;
    step(); cmp_model("auto_load");
    auto_mode = 1'b1;
    run(36, "auto_pass1");
    chk("auto.pass1_ani", animation, 33);
    chk("auto.pass1_done", ani_done, 1);
    run(36, "auto_pass2");
    chk("auto.wrap_ani", animation, 0);
    chk("auto.wrap_frame", frame, 0);
    chk("auto.wrap_done", ani_done, 1);
    auto_mode = 1'b0;

    // lowering speed below the current count ticks immediately
    ani_sel = 6'd0;
    do_reset();
    speed = 3'd3;
    run(20, "slow");
    speed = 3'd0;
    step(); cmp_model("speed_drop");
    chk("speed_drop.stb", frame_stb, 1);
    run(3, "speed_drop2");
    step(); cmp_model("speed_drop3");
    chk("speed_drop.period4", frame_stb, 1);

    // out-of-range select, then limit lowered below the current frame
    do_reset();
    ani_sel = 6'd40; limit = 6'd9;
    step(); cmp_model("oob_sel");
    chk("oob_sel.animation", animation, 0);
    chk("oob_sel.stb", frame_stb, 1);
    run(28, "to_frame7");
    chk("to_frame7.frame", frame, 7);
    limit = 6'd3;
    run(4, "limit_drop");
    chk("limit_drop.frame", frame, 0);
    chk("limit_drop.done", ani_done, 1);

    // freeze while disabled, then reset while disabled
    ani_sel = 6'd0; limit = 6'd9;
    do_reset();
    run(24, "to_frame6");
    chk("to_frame6.frame", frame, 6);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); cmp_model("frozen");
      chk("frozen.frame", frame, 6);
      chk("frozen.stb", frame_stb, 0);
    end
    rst = 1'b1;
    step(); cmp_model("rst_disabled");
    chk("rst_disabled.frame", frame, 0);
    rst = 1'b0; ena = 1'b1;

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0)
        speed = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd0;
      if ($urandom_range(0, 199) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 39) == 0) ani_sel = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0)
        limit = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
      step();
      cmp_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
